rs_rx_framer: RTL and testbench

Parametrised framer between the UART receiver and the Reed-Solomon encoder. It detects each new received byte on the rising edge of `rx_valid` and buffers it in a FIFO. It delivers the bytes as K-symbol message blocks over a valid/ready stream with start/end markers. If the inter-byte gap exceeds a timeout, it closes an incomplete block by zero-padding, so the encoder always sees whole blocks.

---
 rtl/rs_pkg.sv | 21 ++
 rtl/rs_rx_framer_if.sv | 35 +++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/rs_rx_framer.sv | 204 ++++++++++++++++++++
 tb/tb_rs_rx_framer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the Reed-Solomon datapath: the framer FSM state
// encoding and the RS(255,239) code constants. The constants are the
// parameter defaults of the blocks that import this package.
// ---------------------------------------------------------------------------
package rs_pkg;

    // RS(255,239) over GF(2^8)
    localparam int RS_N      = 255;
    localparam int RS_K      = 239;
    localparam int RS_DATA_W = 8;

    // Framer states: waiting for a block, collecting bytes, zero-padding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PAD  = 2'd2
    } framer_state_e;

endpackage

// File: rtl/rs_rx_framer_if.sv
// ---------------------------------------------------------------------------
// rs_rx_framer_if
// Valid/ready symbol stream from the framer to the RS encoder.
//   out_data  : symbol at the head of the stream
//   out_valid : a symbol is being presented
//   out_ready : sink accepts the symbol this cycle
//   out_sop   : presented symbol is the first of a K-symbol block
//   out_eop   : presented symbol is the last of a K-symbol block
// master = framer (source), slave = encoder (sink).
// ---------------------------------------------------------------------------
interface rs_rx_framer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is visible on head_data
// whenever the FIFO is not empty (zero when empty). A push while full is
// accepted only when a pop happens in the same cycle.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data
//   pop        : consume the head entry (ignored when empty)
//   head_data  : current head entry
//   full/empty : occupancy flags
//   fill       : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       fill_q,   fill_d;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (fill_q == '0);
    assign full    = (fill_q == FULL_COUNT);
    assign pop_ok  = pop & ~empty;
    // When full, the slot being written is the one being popped this cycle
    assign push_ok = push & (~full | pop_ok);

    assign head_data = empty ? '0 : mem[rd_ptr_q];
    assign fill      = fill_q;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            fill_d = fill_q + (AW + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            fill_d = fill_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array carries no reset; empty entries are never presented
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rs_rx_framer.sv
// ---------------------------------------------------------------------------
// rs_rx_framer
// Collects bytes from the UART receiver into K-symbol message blocks for the
// RS encoder. Each rising edge of rx_valid captures one byte into a FIFO.
// If a block stays open with no new byte for GAP_TIMEOUT cycles, the rest of
// the block is filled with zero symbols so the encoder always sees whole
// blocks.
//   clk, reset : clock, synchronous active-high reset
//   rx_data    : received byte, valid while rx_valid is high
//   rx_valid   : level strobe from the UART (one byte per high level)
//   out_if     : symbol stream to the encoder (data/valid/ready/sop/eop)
//   fill       : FIFO occupancy
//   err_ovf    : sticky, a byte was lost because the FIFO was full
//   err_drop   : sticky, a byte arrived while padding and was discarded
//   pad_done   : one-cycle pulse after padding completes a block
// ---------------------------------------------------------------------------
module rs_rx_framer
    import rs_pkg::*;
#(
    parameter int DATA_W      = RS_DATA_W,
    parameter int K           = RS_K,
    parameter int FIFO_DEPTH  = 16,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             rx_data,
    input  logic                          rx_valid,
    rs_rx_framer_if.master                out_if,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          err_ovf,
    output logic                          err_drop,
    output logic                          pad_done
);

    localparam int CNT_W = $clog2(K);
    // Keep the gap counter at least one bit wide when padding is disabled
    localparam int GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_SYM  = CNT_W'(K - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);
    localparam bit               PAD_EN    = (GAP_TIMEOUT != 0);

    framer_state_e     state_q, state_d;
    logic              rx_valid_q;
    logic [CNT_W-1:0]  wr_cnt_q,  wr_cnt_d;
    logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              err_ovf_q, err_drop_q, pad_done_q;

    logic              capture;
    logic              pop;
    logic              can_write;
    logic              wr_last;
    logic              sym_last;
    logic              timeout;

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              wr_adv;
    logic              pad_final;
    logic              ovf_evt;
    logic              drop_evt;

    logic [DATA_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .fill      (fill)
    );

    // rx_valid_q resets low, so a level already high when reset releases
    // is seen as a fresh capture on the first cycle out of reset
    assign capture   = rx_valid & ~rx_valid_q;
    assign pop       = ~fifo_empty & out_if.out_ready;
    assign can_write = ~fifo_full | pop;
    assign wr_last   = (wr_cnt_q == LAST_SYM);
    assign sym_last  = (sym_cnt_q == LAST_SYM);
    assign timeout   = PAD_EN && (gap_cnt_q == GAP_LIMIT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A capture in the same cycle as the timeout restarts
    // the gap, so the block keeps filling instead of padding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (capture && can_write) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (capture && can_write && wr_last) begin
                    state_d = S_IDLE;
                end else if (!capture && timeout) begin
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                if (can_write && wr_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: FIFO write request, write-counter advance, error events
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        wr_adv    = 1'b0;
        pad_final = 1'b0;
        ovf_evt   = 1'b0;
        drop_evt  = 1'b0;
        case (state_q)
            S_IDLE, S_FILL: begin
                if (capture) begin
                    if (can_write) begin
                        push      = 1'b1;
                        push_data = rx_data;
                        wr_adv    = 1'b1;
                    end else begin
                        ovf_evt   = 1'b1;
                    end
                end
            end
            S_PAD: begin
                push      = can_write;
                wr_adv    = can_write;
                pad_final = can_write & wr_last;
                drop_evt  = capture;
            end
            default: ;
        endcase
    end

    // Block position counters and the inter-byte gap counter
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        sym_cnt_d = sym_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (wr_adv) begin
            wr_cnt_d = wr_last ? '0 : wr_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            sym_cnt_d = sym_last ? '0 : sym_cnt_q + CNT_W'(1);
        end
        if (state_q != S_FILL || capture) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GAP_LIMIT) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            wr_cnt_q   <= '0;
            sym_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            err_ovf_q  <= 1'b0;
            err_drop_q <= 1'b0;
            pad_done_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            wr_cnt_q   <= wr_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            err_ovf_q  <= err_ovf_q | ovf_evt;
            err_drop_q <= err_drop_q | drop_evt;
            pad_done_q <= pad_final;
        end
    end

    assign out_if.out_data  = head_data;
    assign out_if.out_valid = ~fifo_empty;
    assign out_if.out_sop   = ~fifo_empty & (sym_cnt_q == '0);
    assign out_if.out_eop   = ~fifo_empty & sym_last;

    assign err_ovf  = err_ovf_q;
    assign err_drop = err_drop_q;
    assign pad_done = pad_done_q;

endmodule

// File: tb/tb_rs_rx_framer.sv
// ---------------------------------------------------------------------------
// tb_rs_rx_framer
// Directed bench for rs_rx_framer with K=4, FIFO_DEPTH=4, GAP_TIMEOUT=8.
// A monitor records every accepted symbol (data/sop/eop) and counts
// pad_done pulses; each scenario compares those against hand-written
// expected symbol sequences.
// ---------------------------------------------------------------------------
module tb_rs_rx_framer;

    localparam int DATA_W = 8;
    localparam int K      = 4;
    localparam int DEPTH  = 4;
    localparam int GAP    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  fill;
    logic        err_ovf;
    logic        err_drop;
    logic        pad_done;

    rs_rx_framer_if #(.DATA_W(DATA_W)) outIf ();

    rs_rx_framer #(
        .DATA_W      (DATA_W),
        .K           (K),
        .FIFO_DEPTH  (DEPTH),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .out_if   (outIf),
        .fill     (fill),
        .err_ovf  (err_ovf),
        .err_drop (err_drop),
        .pad_done (pad_done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] popData [64];
    logic       popSop  [64];
    logic       popEop  [64];
    int         popCount   = 0;
    int         padPulses  = 0;
    logic [7:0] expData [16];

    // Inputs change 2 time units after the rising edge; the monitor samples
    // on the falling edge, so an accepted symbol is recorded the half cycle
    // before the edge that pops it
    always @(negedge clk) begin
        if (!reset && outIf.out_valid && outIf.out_ready) begin
            if (popCount < 64) begin
                popData[popCount] = outIf.out_data;
                popSop[popCount]  = outIf.out_sop;
                popEop[popCount]  = outIf.out_eop;
            end
            popCount = popCount + 1;
        end
        if (pad_done) begin
            padPulses = padPulses + 1;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One byte from the UART: level held for 'hold' cycles, then low for 'low'
    task automatic applyStimulus(input logic [7:0] data, input int hold, input int low);
        rx_data  = data;
        rx_valid = 1'b1;
        step(hold);
        rx_valid = 1'b0;
        step(low);
    endtask

    task automatic clearPops();
        for (int i = 0; i < 64; i++) begin
            popData[i] = 'x;
            popSop[i]  = 1'bx;
            popEop[i]  = 1'bx;
        end
        popCount  = 0;
        padPulses = 0;
    endtask

    // Recorded stream must equal expData[0..n-1], starting on a block boundary
    task automatic checkPops(input string tag, input int n);
        checkOutput({tag, " count"}, popCount, n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s[%0d] data", tag, i), popData[i], expData[i]);
            checkOutput($sformatf("%s[%0d] sop", tag, i), popSop[i], 32'(i % K == 0));
            checkOutput($sformatf("%s[%0d] eop", tag, i), popEop[i], 32'(i % K == K - 1));
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " out_valid"}, outIf.out_valid, 0);
        checkOutput({tag, " out_sop"},   outIf.out_sop,   0);
        checkOutput({tag, " out_eop"},   outIf.out_eop,   0);
        checkOutput({tag, " out_data"},  outIf.out_data,  0);
        checkOutput({tag, " fill"},      fill,            0);
        checkOutput({tag, " err_ovf"},   err_ovf,         0);
        checkOutput({tag, " err_drop"},  err_drop,        0);
        checkOutput({tag, " pad_done"},  pad_done,        0);
    endtask

    initial begin
        reset           = 1'b1;
        rx_valid        = 1'b0;
        rx_data         = 8'h00;
        outIf.out_ready = 1'b0;
        clearPops();
        step(3);
        checkIdleOutputs("reset");
        reset = 1'b0;
        step(2);
        checkIdleOutputs("post-reset");

        // 1: one full block, sink always ready
        $display("[TB] scenario 1: full block, ready high");
        outIf.out_ready = 1'b1;
        clearPops();
        applyStimulus(8'h11, 5, 2);
        applyStimulus(8'h22, 5, 2);
        applyStimulus(8'h33, 5, 2);
        applyStimulus(8'h44, 5, 2);
        step(5);
        expData[0] = 8'h11; expData[1] = 8'h22; expData[2] = 8'h33; expData[3] = 8'h44;
        checkPops("s1", 4);
        checkOutput("s1 err_ovf", err_ovf, 0);
        checkOutput("s1 err_drop", err_drop, 0);
        checkOutput("s1 pad pulses", padPulses, 0);

        // 2: two bytes then silence, block closed by padding
        $display("[TB] scenario 2: gap timeout padding");
        clearPops();
        applyStimulus(8'hA1, 2, 1);
        applyStimulus(8'hA2, 2, 1);
        step(3);
        checkOutput("s2 no pad before timeout", popCount, 2);
        step(20);
        expData[0] = 8'hA1; expData[1] = 8'hA2; expData[2] = 8'h00; expData[3] = 8'h00;
        checkPops("s2", 4);
        checkOutput("s2 pad pulses", padPulses, 1);
        checkOutput("s2 fill", fill, 0);

        // 3: sink stalled, six captures overflow a four-entry FIFO
        $display("[TB] scenario 3: overflow");
        outIf.out_ready = 1'b0;
        clearPops();
        applyStimulus(8'h31, 1, 1);
        applyStimulus(8'h32, 1, 1);
        applyStimulus(8'h33, 1, 1);
        applyStimulus(8'h34, 1, 1);
        applyStimulus(8'h35, 1, 1);
        applyStimulus(8'h36, 1, 1);
        step(2);
        checkOutput("s3 fill", fill, 4);
        checkOutput("s3 err_ovf", err_ovf, 1);
        checkOutput("s3 head data", outIf.out_data, 8'h31);
        checkOutput("s3 head sop", outIf.out_sop, 1);
        checkOutput("s3 stalled pops", popCount, 0);
        outIf.out_ready = 1'b1;
        step(8);
        expData[0] = 8'h31; expData[1] = 8'h32; expData[2] = 8'h33; expData[3] = 8'h34;
        checkPops("s3", 4);
        checkOutput("s3 err_ovf sticky", err_ovf, 1);

        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);

        // 4: FIFO full, capture and pop on the same edge
        $display("[TB] scenario 4: push and pop while full");
        outIf.out_ready = 1'b0;
        clearPops();
        applyStimulus(8'h41, 1, 1);
        applyStimulus(8'h42, 1, 1);
        applyStimulus(8'h43, 1, 1);
        applyStimulus(8'h44, 1, 1);
        step(1);
        checkOutput("s4 fill full", fill, 4);
        rx_data         = 8'h45;
        rx_valid        = 1'b1;
        outIf.out_ready = 1'b1;
        step(1);
        outIf.out_ready = 1'b0;
        checkOutput("s4 fill after push+pop", fill, 4);
        checkOutput("s4 err_ovf", err_ovf, 0);
        rx_valid = 1'b0;
        step(1);
        outIf.out_ready = 1'b1;
        step(25);
        expData[0] = 8'h41; expData[1] = 8'h42; expData[2] = 8'h43; expData[3] = 8'h44;
        expData[4] = 8'h45; expData[5] = 8'h00; expData[6] = 8'h00; expData[7] = 8'h00;
        checkPops("s4", 8);
        checkOutput("s4 pad pulses", padPulses, 1);
        checkOutput("s4 err_ovf end", err_ovf, 0);

        // 5: byte arriving while padding is stalled on a full FIFO
        $display("[TB] scenario 5: capture during padding");
        outIf.out_ready = 1'b0;
        clearPops();
        applyStimulus(8'h51, 1, 1);
        applyStimulus(8'h52, 1, 1);
        applyStimulus(8'h53, 1, 1);
        applyStimulus(8'h54, 1, 1);
        outIf.out_ready = 1'b1;
        step(2);
        outIf.out_ready = 1'b0;
        checkOutput("s5 fill after two pops", fill, 2);
        applyStimulus(8'h55, 1, 1);
        applyStimulus(8'h56, 1, 1);
        step(14);
        checkOutput("s5 fill stalled", fill, 4);
        checkOutput("s5 err_drop before", err_drop, 0);
        applyStimulus(8'h57, 1, 1);
        checkOutput("s5 err_drop", err_drop, 1);
        checkOutput("s5 err_ovf", err_ovf, 0);
        outIf.out_ready = 1'b1;
        step(20);
        expData[0] = 8'h51; expData[1] = 8'h52; expData[2] = 8'h53; expData[3] = 8'h54;
        expData[4] = 8'h55; expData[5] = 8'h56; expData[6] = 8'h00; expData[7] = 8'h00;
        checkPops("s5", 8);
        checkOutput("s5 pad pulses", padPulses, 1);
        checkOutput("s5 err_drop sticky", err_drop, 1);

        // 6: reset in the middle of a block; rx_valid high across reset release
        $display("[TB] scenario 6: reset mid-block");
        outIf.out_ready = 1'b0;
        clearPops();
        applyStimulus(8'h61, 1, 1);
        applyStimulus(8'h62, 1, 1);
        checkOutput("s6 fill before reset", fill, 2);
        reset    = 1'b1;
        rx_data  = 8'h71;
        rx_valid = 1'b1;
        step(2);
        checkIdleOutputs("s6 in reset");
        reset           = 1'b0;
        outIf.out_ready = 1'b1;
        step(2);
        rx_valid = 1'b0;
        step(1);
        applyStimulus(8'h72, 1, 1);
        applyStimulus(8'h73, 1, 1);
        applyStimulus(8'h74, 1, 1);
        step(4);
        expData[0] = 8'h71; expData[1] = 8'h72; expData[2] = 8'h73; expData[3] = 8'h74;
        checkPops("s6", 4);
        checkOutput("s6 pad pulses", padPulses, 0);
        checkOutput("s6 err_ovf", err_ovf, 0);
        checkOutput("s6 err_drop", err_drop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
